// File: rtl/sr_bank_writer_pkg.sv
// Shared types and constants for the SR bank write driver.
package sr_bank_writer_pkg;

  localparam int unsigned CNT_W            = $clog2(16);
  localparam int unsigned DEF_WIDTH        = 8;
  localparam int unsigned DEF_PULSE_CYCLES = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    GAP1  = 3'd2,
    CLR   = 3'd3,
    GAP2  = 3'd4,
    CHECK = 3'd5
  } state_t;

endpackage

// File: rtl/sr_bank_writer_timer.sv
// Loadable down-counter timing the SET/CLR hold; expire is high while the count is zero.
module sr_pulse_timer
  import sr_bank_writer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)              r_cnt <= '0;
    else if (load)           r_cnt <= load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - 1'b1;
  end

  assign expire = (r_cnt == '0);

endmodule

// File: rtl/sr_bank_writer.sv
// Write-side driver for a bank of SR flip-flops: set phase, gap, reset phase, gap, readback.
// Optional SR_BANK_WRITER_DELTA_EN: pulse only bits that differ from the bank's value at acceptance.
module sr_bank_writer
  import sr_bank_writer_pkg::*;
#(
  parameter int unsigned WIDTH        = DEF_WIDTH,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(PULSE_CYCLES - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_dreg, w_dreg_nxt;
  logic [WIDTH-1:0] w_set_mask, w_clr_mask;
  logic             w_accept, w_load, w_expire;

`ifdef SR_BANK_WRITER_DELTA_EN
  logic [WIDTH-1:0] r_qsnap, w_qsnap_nxt;
`endif

  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid & req_ready;

  sr_pulse_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (LOAD_VAL),
    .expire   (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_dreg_nxt  = r_dreg;
    w_load      = 1'b0;
    case (r_state)
      IDLE: if (w_accept) begin
        w_dreg_nxt  = req_data;
        w_load      = 1'b1;
        w_state_nxt = SET;
`ifdef SR_BANK_WRITER_DELTA_EN
        // Nothing to change: skip via GAP2 so done still lands 3 cycles after acceptance
        if (req_data == q_in) w_state_nxt = GAP2;
`endif
      end
      SET:     if (w_expire) w_state_nxt = GAP1;
      GAP1: begin
        w_load      = 1'b1;
        w_state_nxt = CLR;
      end
      CLR:     if (w_expire) w_state_nxt = GAP2;
      GAP2:    w_state_nxt = CHECK;
      CHECK:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Phase masks use next-cycle data so the registered lines are valid on the first SET cycle
`ifdef SR_BANK_WRITER_DELTA_EN
  assign w_qsnap_nxt = w_accept ? q_in : r_qsnap;
  assign w_set_mask  =  w_dreg_nxt & ~w_qsnap_nxt;
  assign w_clr_mask  = ~w_dreg_nxt &  w_qsnap_nxt;
`else
  assign w_set_mask  =  w_dreg_nxt;
  assign w_clr_mask  = ~w_dreg_nxt;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_dreg  <= '0;
      s_out   <= '0;
      r_out   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
`ifdef SR_BANK_WRITER_DELTA_EN
      r_qsnap <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_dreg  <= w_dreg_nxt;
      s_out   <= (w_state_nxt == SET) ? w_set_mask : '0;
      r_out   <= (w_state_nxt == CLR) ? w_clr_mask : '0;
      done    <= (r_state == CHECK);
      if (w_accept)               err <= 1'b0;
      else if (r_state == CHECK)  err <= |(q_in ^ r_dreg);
`ifdef SR_BANK_WRITER_DELTA_EN
      r_qsnap <= w_qsnap_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_sr_bank_writer.sv
// Bench for sr_bank_writer: two instances (P=1, P=3) each driving a behavioural SR bank with stuck-at-0 faults.
module tb_sr_bank_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bank_clr;
  logic       rv [2];
  logic       rr [2];
  logic [7:0] rd [2];
  logic [7:0] so [2];
  logic [7:0] ro [2];
  logic [7:0] qi [2];
  logic       dn [2];
  logic       er [2];
  logic [7:0] bank  [2];
  logic [7:0] stuck [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign qi[0] = bank[0] & ~stuck[0];
  assign qi[1] = bank[1] & ~stuck[1];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (bank_clr) bank[k] <= '0;
      else          bank[k] <= (bank[k] | so[k]) & ~ro[k];
    end
  end

  sr_bank_writer #(.WIDTH(8), .PULSE_CYCLES(1)) u_dut_p1 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[0]), .req_ready(rr[0]), .req_data(rd[0]),
    .s_out(so[0]), .r_out(ro[0]), .q_in(qi[0]), .done(dn[0]), .err(er[0])
  );

  sr_bank_writer #(.WIDTH(8), .PULSE_CYCLES(3)) u_dut_p3 (
    .clk(clk), .rst_n(rst_n), .req_valid(rv[1]), .req_ready(rr[1]), .req_data(rd[1]),
    .s_out(so[1]), .r_out(ro[1]), .q_in(qi[1]), .done(dn[1]), .err(er[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) chk("no_overlap", 32'(so[k] & ro[k]), 0);
  end

  // Entered at a negedge with rv[k]=1 and rd[k]=data already driven; returns at the negedge of the done cycle.
  task automatic run_write(input int k, input int p, input logic [7:0] data);
    logic [7:0] q0, smask, rmask, qfin, sx, rx;
    int         last;
    bit         exp_err;
    chk("ready_at_accept", rr[k], 1);
    q0 = qi[k];
`ifdef SR_BANK_WRITER_DELTA_EN
    smask = data & ~q0;
    rmask = ~data & q0;
    last  = (data == q0) ? 3 : 2 * p + 4;
`else
    smask = data;
    rmask = ~data;
    last  = 2 * p + 4;
`endif
    qfin    = ((bank[k] | smask) & ~rmask) & ~stuck[k];
    exp_err = (qfin != data);
    @(posedge clk);
    #1 rv[k] = 1'b0;
    rd[k] = 8'($urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      sx = (c <= p) ? smask : 8'h00;
      rx = (c >= p + 2 && c <= 2 * p + 1) ? rmask : 8'h00;
      chk("s_out", so[k], sx);
      chk("r_out", ro[k], rx);
      chk("done",  dn[k], (c == last) ? 1 : 0);
      chk("ready", rr[k], (c == last) ? 1 : 0);
      chk("err",   er[k], (c == last) ? 32'(exp_err) : 0);
    end
    chk("bank_q", qi[k], qfin);
  endtask

  initial begin
    int         k, p;
    logic [7:0] d;
    rst_n    = 1'b0;
    bank_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rd[i] = '0; stuck[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    bank_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_s",     so[i], 0);
      chk("rst_r",     ro[i], 0);
      chk("rst_done",  dn[i], 0);
      chk("rst_err",   er[i], 0);
      chk("rst_ready", rr[i], 1);
    end

    // Basic write, P=1
    @(negedge clk); rv[0] = 1'b1; rd[0] = 8'hA5;
    run_write(0, 1, 8'hA5);

    // Pulse width, P=3
    @(negedge clk); rv[1] = 1'b1; rd[1] = 8'h0F;
    run_write(1, 3, 8'h0F);

    // Readback error: bit 2 stuck low
    @(negedge clk); stuck[0] = 8'h04; rv[0] = 1'b1; rd[0] = 8'hFF;
    run_write(0, 1, 8'hFF);

    // Err cleared by next acceptance, then back-to-back in the done cycle
    @(negedge clk); stuck[0] = '0; rv[0] = 1'b1; rd[0] = 8'h3C;
    run_write(0, 1, 8'h3C);
    rv[0] = 1'b1; rd[0] = 8'hC3;
    run_write(0, 1, 8'hC3);

    for (int n = 0; n < 24; n++) begin
      k = int'($urandom_range(0, 1));
      p = (k == 1) ? 3 : 1;
      d = 8'($urandom);
      @(negedge clk);
      stuck[k] = ($urandom_range(0, 3) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
      rd[k] = 8'($urandom);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        rd[k] = 8'($urandom);
      end
      rv[k] = 1'b1; rd[k] = d;
      run_write(k, p, d);
    end

    // Reset during SET aborts without done
    @(negedge clk); stuck[0] = '0; rv[0] = 1'b1; rd[0] = 8'hA5;
    @(posedge clk);
    #1 rv[0] = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_s_before", so[0], 8'hA5);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_s",     so[0], 0);
    chk("midrst_r",     ro[0], 0);
    chk("midrst_ready", rr[0], 1);
    repeat (8) begin
      @(negedge clk);
      chk("midrst_no_done", dn[0], 0);
    end

`ifdef SR_BANK_WRITER_DELTA_EN
    @(negedge clk); rv[0] = 1'b1; rd[0] = 8'hA5;
    run_write(0, 1, 8'hA5);
    @(negedge clk); rv[0] = 1'b1; rd[0] = 8'hA5;
    run_write(0, 1, 8'hA5);
    @(negedge clk); rv[0] = 1'b1; rd[0] = 8'hA4;
    run_write(0, 1, 8'hA4);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
